// File: rtl/bitserial_alu_seq.sv
// ---------------------------------------------------------------------------
// bitserial_alu_seq
//
// Purpose:
//   Sequencer/ALU placed directly in front of the 16-lane bit-sliced BRAM.
//   It owns both BRAM ports. Port A reads operand A and writes the result.
//   Port B reads operand B. Fields are processed LSB-first, two cycles per
//   bit (READ then WRITE). All lanes compute in parallel, each with its own
//   carry.
//
// Optional feature:
//   Define BITSEQ_ZERO_FLAG_EN to add o_zero_out. A lane's bit in o_zero_out
//   is 1 when every result bit written for that lane was 0.
//
// Ports:
//   i_clk          clock, rising edge
//   i_reset        asynchronous reset, active LOW
//   i_cmd_valid    command offered
//   o_cmd_ready    high only while idle; accept = valid & ready
//   i_cmd_op       0 COPY A, 1 NOT A, 2 AND, 3 OR, 4 XOR, 5 ADD, 6 SUB, 7 COPY B
//   i_cmd_src_a    base bit address of operand A
//   i_cmd_src_b    base bit address of operand B
//   i_cmd_dst      base bit address of the result
//   i_cmd_len      field length in bits (clamped to MAX_WORD_LENGTH)
//   o_bram_wea     BRAM port A write enable
//   o_bram_addra   BRAM port A address
//   o_bram_dia     BRAM port A write data (one result bit per lane)
//   i_bram_doa     BRAM port A read data (one-cycle registered latency)
//   o_bram_addrb   BRAM port B address (read only)
//   o_bram_web     BRAM port B write enable, tied low
//   o_bram_dib     BRAM port B write data, tied low
//   i_bram_dob     BRAM port B read data
//   o_busy         high from accept until done
//   o_done         one-cycle pulse at the end of a command
//   o_zero_out     per-lane all-zero result flag (BITSEQ_ZERO_FLAG_EN only)
//   o_carry_out    per-lane final carry (ADD) or no-borrow (SUB); 0 otherwise
// ---------------------------------------------------------------------------
module bitserial_alu_seq #(
  parameter int MAX_WORD_LENGTH = 32,
  parameter int LANES           = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [2:0]       i_cmd_op,
  input  logic [9:0]       i_cmd_src_a,
  input  logic [9:0]       i_cmd_src_b,
  input  logic [9:0]       i_cmd_dst,
  input  logic [5:0]       i_cmd_len,
  output logic             o_bram_wea,
  output logic [9:0]       o_bram_addra,
  output logic [LANES-1:0] o_bram_dia,
  input  logic [LANES-1:0] i_bram_doa,
  output logic [9:0]       o_bram_addrb,
  output logic             o_bram_web,
  output logic [LANES-1:0] o_bram_dib,
  input  logic [LANES-1:0] i_bram_dob,
  output logic             o_busy,
  output logic             o_done,
`ifdef BITSEQ_ZERO_FLAG_EN
  output logic [LANES-1:0] o_zero_out,
`endif
  output logic [LANES-1:0] o_carry_out
);

  localparam logic [2:0] OP_COPY_A = 3'd0;
  localparam logic [2:0] OP_NOT_A  = 3'd1;
  localparam logic [2:0] OP_AND    = 3'd2;
  localparam logic [2:0] OP_OR     = 3'd3;
  localparam logic [2:0] OP_XOR    = 3'd4;
  localparam logic [2:0] OP_ADD    = 3'd5;
  localparam logic [2:0] OP_SUB    = 3'd6;
  localparam logic [2:0] OP_COPY_B = 3'd7;

  localparam logic [5:0] LP_MAX_LEN = 6'(MAX_WORD_LENGTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [2:0]       r_op;
  logic [9:0]       r_src_a;
  logic [9:0]       r_src_b;
  logic [9:0]       r_dst;
  logic [5:0]       r_len;
  logic [5:0]       r_bit;
  logic [LANES-1:0] r_carry;
  logic [LANES-1:0] r_carry_out;
`ifdef BITSEQ_ZERO_FLAG_EN
  logic [LANES-1:0] r_zero;
  logic [LANES-1:0] r_zero_out;
`endif

  logic             w_accept;
  logic [5:0]       w_cmd_len;
  logic             w_last;
  logic             w_is_arith;
  logic [LANES-1:0] w_b_eff;
  logic [LANES-1:0] w_result;
  logic [LANES-1:0] w_carry_next;

  assign w_accept   = i_cmd_valid && (r_state == ST_IDLE);
  assign w_cmd_len  = (i_cmd_len > LP_MAX_LEN) ? LP_MAX_LEN : i_cmd_len;
  assign w_last     = (r_bit == (r_len - 6'd1));
  assign w_is_arith = (r_op == OP_ADD) || (r_op == OP_SUB);

  // Subtraction is A + ~B + 1: B is inverted here and the carry starts at 1.
  assign w_b_eff = (r_op == OP_SUB) ? ~i_bram_dob : i_bram_dob;

  assign o_bram_web  = 1'b0;
  assign o_bram_dib  = '0;
  assign o_carry_out = r_carry_out;
`ifdef BITSEQ_ZERO_FLAG_EN
  assign o_zero_out  = r_zero_out;
`endif

  // Per-lane result bit for the current position. The BRAM read data is
  // only meaningful in WRITE, which is the only state that uses it.
  always_comb begin
    w_result     = '0;
    w_carry_next = r_carry;
    case (r_op)
      OP_COPY_A: w_result = i_bram_doa;
      OP_NOT_A:  w_result = ~i_bram_doa;
      OP_AND:    w_result = i_bram_doa & i_bram_dob;
      OP_OR:     w_result = i_bram_doa | i_bram_dob;
      OP_XOR:    w_result = i_bram_doa ^ i_bram_dob;
      OP_ADD, OP_SUB: begin
        w_result     = i_bram_doa ^ w_b_eff ^ r_carry;
        w_carry_next = (i_bram_doa & w_b_eff) | (r_carry & (i_bram_doa ^ w_b_eff));
      end
      OP_COPY_B: w_result = i_bram_dob;
      default:   w_result = '0;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and BRAM/handshake outputs. Addresses are 10 bits, so
  // base + bit index wraps modulo 1024 on its own.
  always_comb begin
    w_state_next = r_state;
    o_cmd_ready  = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_bram_wea   = 1'b0;
    o_bram_addra = '0;
    o_bram_addrb = '0;
    o_bram_dia   = '0;
    case (r_state)
      ST_IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          w_state_next = (w_cmd_len == 6'd0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        o_busy       = 1'b1;
        o_bram_addra = r_src_a + 10'(r_bit);
        o_bram_addrb = r_src_b + 10'(r_bit);
        w_state_next = ST_WRITE;
      end
      ST_WRITE: begin
        o_busy       = 1'b1;
        o_bram_wea   = 1'b1;
        o_bram_addra = r_dst + 10'(r_bit);
        o_bram_dia   = w_result;
        w_state_next = w_last ? ST_DONE : ST_READ;
      end
      ST_DONE: begin
        o_busy       = 1'b1;
        o_done       = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Command latch, bit counter and per-lane carry/zero tracking. The
  // visible carry_out (and zero_out) are loaded on the edge that enters
  // DONE, so they are already valid while done is high.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_op        <= '0;
      r_src_a     <= '0;
      r_src_b     <= '0;
      r_dst       <= '0;
      r_len       <= '0;
      r_bit       <= '0;
      r_carry     <= '0;
      r_carry_out <= '0;
`ifdef BITSEQ_ZERO_FLAG_EN
      r_zero      <= '0;
      r_zero_out  <= '0;
`endif
    end else begin
      if (w_accept) begin
        r_op    <= i_cmd_op;
        r_src_a <= i_cmd_src_a;
        r_src_b <= i_cmd_src_b;
        r_dst   <= i_cmd_dst;
        r_len   <= w_cmd_len;
        r_bit   <= '0;
        r_carry <= (i_cmd_op == OP_SUB) ? '1 : '0;
`ifdef BITSEQ_ZERO_FLAG_EN
        r_zero  <= '1;
`endif
        if (w_cmd_len == 6'd0) begin
          r_carry_out <= '0;
`ifdef BITSEQ_ZERO_FLAG_EN
          r_zero_out  <= '1;
`endif
        end
      end else if (r_state == ST_WRITE) begin
        r_carry <= w_carry_next;
        r_bit   <= r_bit + 6'd1;
`ifdef BITSEQ_ZERO_FLAG_EN
        r_zero  <= r_zero & ~w_result;
`endif
        if (w_last) begin
          r_carry_out <= w_is_arith ? w_carry_next : '0;
`ifdef BITSEQ_ZERO_FLAG_EN
          r_zero_out  <= r_zero & ~w_result;
`endif
        end
      end
    end
  end

endmodule
